// File: rtl/crc_host_pkg.sv
// crc_host_pkg: register map, AHB encodings and host-interface FSM states
package crc_host_pkg;
    localparam logic [2:0] OFF_DR   = 3'd0;
    localparam logic [2:0] OFF_IDR  = 3'd1;
    localparam logic [2:0] OFF_CR   = 3'd2;
    localparam logic [2:0] OFF_INIT = 3'd4;
    localparam logic [2:0] OFF_POL  = 3'd5;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
    function automatic logic is_err_off(input logic [2:0] off);
        return off inside {3'd3, 3'd6, 3'd7};
    endfunction
endpackage

// File: rtl/crc_ch_cfg.sv
// crc_ch_cfg: one channel's CR register split into its configuration fields
module crc_ch_cfg
    import crc_host_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       wr_en,
    input  logic [4:0] wr_data,
    output logic [4:0] cr,
    output logic [1:0] poly_size,
    output logic [1:0] rev_in,
    output logic       rev_out
);
    always_ff @(posedge HCLK) begin
        if (HRESET)
            cr <= '0;
        else if (wr_en)
            cr <= wr_data;
    end
    assign poly_size = cr[1:0];
    assign rev_in    = cr[3:2];
    assign rev_out   = cr[4];
endmodule

// File: rtl/crc_host_if_mc.sv
// crc_host_if_mc: AHB-lite slave front end for N_CH CRC channels
module crc_host_if_mc
    import crc_host_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int WAIT_MAX = 15
)
(
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSElx,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [N_CH-1:0]     ch_sel,
    output logic                buffer_write_en,
    output logic                crc_init_en,
    output logic                crc_idr_en,
    output logic                crc_poly_en,
    output logic                reset_chain,
    output logic [31:0]         bus_wr,
    output logic [1:0]          bus_size,
    output logic [2*N_CH-1:0]   crc_poly_size,
    output logic [2*N_CH-1:0]   rev_in_type,
    output logic [N_CH-1:0]     rev_out_type,
    input  logic [32*N_CH-1:0]  crc_out,
    input  logic [32*N_CH-1:0]  crc_init_out,
    input  logic [32*N_CH-1:0]  crc_poly_out,
    input  logic [8*N_CH-1:0]   crc_idr_out,
    input  logic [N_CH-1:0]     buffer_full,
    input  logic [N_CH-1:0]     reset_pending,
    input  logic [N_CH-1:0]     read_wait
);
    state_t      state, state_nx;
    logic [1:0]  d_ch, a_ch, d_size;
    logic [2:0]  d_off, a_off;
    logic        d_write;
    logic [7:0]  wcnt;
    logic        a_valid, a_err, sample, in_data, stall, timeout, done, wr_done;
    logic        bf, rw, rp;
    logic [31:0] rd_dr, rd_init, rd_pol;
    logic [7:0]  rd_idr;
    logic [4:0]  rd_cr;
    logic [4:0]  cr [N_CH];
    logic [N_CH-1:0] cr_we;
    logic        unused_addr;

    assign unused_addr = ^{HADDR[31:7], HADDR[1:0]};
    assign a_ch    = HADDR[6:5];
    assign a_off   = HADDR[4:2];
    assign a_valid = HSElx && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign a_err   = is_err_off(a_off) || int'(a_ch) >= N_CH ||
                     (HWRITE && a_off == OFF_CR && HSIZE != HSIZE_WORD);

    always_comb begin
        bf = 1'b0;
        rw = 1'b0;
        rp = 1'b0;
        rd_dr = '0;
        rd_idr = '0;
        rd_init = '0;
        rd_pol = '0;
        rd_cr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (d_ch == 2'(i)) begin
                bf = buffer_full[i];
                rw = read_wait[i];
                rp = reset_pending[i];
                rd_dr = crc_out[32*i +: 32];
                rd_idr = crc_idr_out[8*i +: 8];
                rd_init = crc_init_out[32*i +: 32];
                rd_pol = crc_poly_out[32*i +: 32];
                rd_cr = cr[i];
            end
        end
    end

    // Reset gates every output so an interrupted stall or error never completes.
    assign in_data   = !HRESET && state == ST_DATA;
    assign stall     = in_data && ((d_off == OFF_DR && (d_write ? bf : rw)) ||
                                   (d_off == OFF_INIT && d_write && rp));
    assign timeout   = stall && wcnt == 8'(WAIT_MAX - 1);
    assign done      = in_data && !stall;
    assign wr_done   = done && d_write;
    assign HREADYOUT = HRESET || !(stall || state == ST_ERR1);
    assign HRESP     = (!HRESET && (state == ST_ERR1 || state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign sample    = HREADY && HREADYOUT && !HRESET;

    always_comb begin
        state_nx = ST_IDLE;
        if (sample && a_valid)
            state_nx = a_err ? ST_ERR1 : ST_DATA;
        if (stall)
            state_nx = timeout ? ST_ERR1 : ST_DATA;
        if (state == ST_ERR1)
            state_nx = ST_ERR2;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            d_ch    <= '0;
            d_off   <= '0;
            d_write <= 1'b0;
            d_size  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (stall && !timeout) ? wcnt + 8'd1 : '0;
            if (sample && a_valid) begin
                d_ch    <= a_ch;
                d_off   <= a_off;
                d_write <= HWRITE;
                d_size  <= HSIZE[1:0];
            end
        end
    end

    assign buffer_write_en = wr_done && d_off == OFF_DR;
    assign crc_idr_en      = wr_done && d_off == OFF_IDR;
    assign crc_init_en     = wr_done && d_off == OFF_INIT;
    assign crc_poly_en     = wr_done && d_off == OFF_POL;
    assign reset_chain     = wr_done && d_off == OFF_CR && HWDATA[0];
    assign bus_wr          = HWDATA;
    assign bus_size        = d_size;
    assign HRDATA = (done && !d_write) ?
                    (d_off == OFF_DR   ? rd_dr :
                     d_off == OFF_IDR  ? {24'h0, rd_idr} :
                     d_off == OFF_CR   ? {24'h0, rd_cr, 3'h0} :
                     d_off == OFF_INIT ? rd_init :
                     d_off == OFF_POL  ? rd_pol : 32'h0) : 32'h0;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_sel[c] = in_data && d_ch == 2'(c);
        assign cr_we[c]  = wr_done && d_off == OFF_CR && d_ch == 2'(c);
        crc_ch_cfg u_cfg (
            .HCLK      (HCLK),
            .HRESET    (HRESET),
            .wr_en     (cr_we[c]),
            .wr_data   (HWDATA[7:3]),
            .cr        (cr[c]),
            .poly_size (crc_poly_size[2*c +: 2]),
            .rev_in    (rev_in_type[2*c +: 2]),
            .rev_out   (rev_out_type[c])
        );
    end
endmodule

// File: tb/tb_crc_host_if_mc.sv
// tb_crc_host_if_mc: directed AHB transfers checked against a transaction-level model
module tb_crc_host_if_mc;
    import crc_host_pkg::*;
    localparam int NC = 2;
    localparam int WM = 4;

    logic HCLK = 1'b0, HRESET = 1'b1, HSElx = 1'b0, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0] HTRANS = HTRANS_IDLE;
    logic [2:0] HSIZE = HSIZE_WORD;
    logic HREADY;
    logic [31:0] HRDATA, bus_wr;
    logic HREADYOUT, HRESP, buffer_write_en, crc_init_en, crc_idr_en, crc_poly_en, reset_chain;
    logic [NC-1:0] ch_sel, rev_out_type;
    logic [1:0] bus_size;
    logic [2*NC-1:0] crc_poly_size, rev_in_type;
    logic [32*NC-1:0] crc_out = {32'hC1C1_5A5A, 32'hC0C0_A5A5};
    logic [32*NC-1:0] crc_init_out = {32'h1111_2222, 32'h3333_4444};
    logic [32*NC-1:0] crc_poly_out = {32'h04C1_1DB7, 32'h1EDC_6F41};
    logic [8*NC-1:0] crc_idr_out = {8'hB1, 8'hA0};
    logic [NC-1:0] buffer_full = '0, reset_pending = '0, read_wait = '0;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    crc_host_if_mc #(.N_CH(NC), .WAIT_MAX(WM)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSElx(HSElx), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .ch_sel(ch_sel),
        .buffer_write_en(buffer_write_en), .crc_init_en(crc_init_en), .crc_idr_en(crc_idr_en),
        .crc_poly_en(crc_poly_en), .reset_chain(reset_chain), .bus_wr(bus_wr), .bus_size(bus_size),
        .crc_poly_size(crc_poly_size), .rev_in_type(rev_in_type), .rev_out_type(rev_out_type),
        .crc_out(crc_out), .crc_init_out(crc_init_out), .crc_poly_out(crc_poly_out),
        .crc_idr_out(crc_idr_out), .buffer_full(buffer_full), .reset_pending(reset_pending),
        .read_wait(read_wait)
    );

    int n_chk = 0, n_err = 0;
    int n_bwe = 0, n_str = 0, n_stall = 0, n_err1 = 0, n_err2 = 0, n_rc = 0, n_poly = 0, run = 0, max_run = 0;
    int s_bwe, s_str, s_stall, s_err1, s_err2, s_rc, s_poly;
    logic [1:0] poly_chsel = '0;
    logic poly_rdy = 1'b0, poly_resp = 1'b1;
    logic [31:0] rd_last = '0;
    logic [31:0] wq [$];

    // model: phase 0 none, 1 data, 2 first error cycle, 3 second error cycle
    int m_ph = 0, m_ch = 0, m_off = 0, m_stall = 0;
    logic m_wr = 1'b0;
    logic [1:0] m_size = '0;
    logic [4:0] m_cr [NC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input int ch, input int off);
        case (off)
            0: return crc_out[32*ch +: 32];
            1: return {24'h0, crc_idr_out[8*ch +: 8]};
            2: return {24'h0, m_cr[ch], 3'h0};
            4: return crc_init_out[32*ch +: 32];
            5: return crc_poly_out[32*ch +: 32];
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge HCLK) begin
        logic st, tmo, fin, rdy, bad;
        n_bwe += int'(buffer_write_en);
        n_str += int'(buffer_write_en) + int'(crc_init_en) + int'(crc_idr_en) + int'(crc_poly_en) + int'(reset_chain);
        n_stall += int'(!HREADYOUT && !HRESP);
        n_err1 += int'(HRESP && !HREADYOUT);
        n_err2 += int'(HRESP && HREADYOUT);
        n_rc += int'(reset_chain);
        n_poly += int'(crc_poly_en);
        run = buffer_write_en ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (buffer_write_en) wq.push_back(bus_wr);
        if (crc_poly_en) begin poly_chsel = ch_sel; poly_rdy = HREADYOUT; poly_resp = HRESP; end
        if (HREADYOUT && HRDATA != 0) rd_last = HRDATA;
        if (HRESET) begin
            chk("rst_hreadyout", HREADYOUT, 1);
            chk("rst_hresp", HRESP, 0);
            chk("rst_hrdata", HRDATA, 0);
            chk("rst_ch_sel", ch_sel, 0);
            chk("rst_strobes", {buffer_write_en, crc_init_en, crc_idr_en, crc_poly_en, reset_chain}, 0);
            m_ph = 0; m_stall = 0;
            foreach (m_cr[c]) m_cr[c] = '0;
        end else begin
            st = m_ph == 1 && ((m_off == 0 && (m_wr ? buffer_full[m_ch] : read_wait[m_ch])) ||
                               (m_off == 4 && m_wr && reset_pending[m_ch]));
            tmo = st && (m_stall + 1 == WM);
            fin = m_ph == 1 && !st;
            rdy = !(st || m_ph == 2);
            chk("hreadyout", HREADYOUT, rdy);
            chk("hresp", HRESP, m_ph >= 2);
            chk("ch_sel", ch_sel, m_ph == 1 ? (1 << m_ch) : 0);
            chk("buffer_write_en", buffer_write_en, fin && m_wr && m_off == 0);
            chk("crc_idr_en", crc_idr_en, fin && m_wr && m_off == 1);
            chk("crc_init_en", crc_init_en, fin && m_wr && m_off == 4);
            chk("crc_poly_en", crc_poly_en, fin && m_wr && m_off == 5);
            chk("reset_chain", reset_chain, fin && m_wr && m_off == 2 && HWDATA[0]);
            chk("hrdata", HRDATA, (fin && !m_wr) ? reg_val(m_ch, m_off) : 32'h0);
            if (m_ph == 1) chk("bus_size", bus_size, m_size);
            for (int c = 0; c < NC; c++) begin
                chk("poly_size", crc_poly_size[2*c +: 2], m_cr[c][1:0]);
                chk("rev_in", rev_in_type[2*c +: 2], m_cr[c][3:2]);
                chk("rev_out", rev_out_type[c], m_cr[c][4]);
            end
            if (fin && m_wr && m_off == 2) m_cr[m_ch] = HWDATA[7:3];
            bad = HADDR[4:2] inside {3'd3, 3'd6, 3'd7} || HADDR[6:5] >= 2 ||
                  (HWRITE && HADDR[4:2] == 3'd2 && HSIZE != 3'b010);
            m_stall = (st && !tmo) ? m_stall + 1 : 0;
            if (m_ph == 2) m_ph = 3;
            else if (tmo) m_ph = 2;
            else if (st) m_ph = 1;
            else if (rdy && HSElx && HTRANS[1]) begin
                m_ph = bad ? 2 : 1;
                m_ch = int'(HADDR[6:5]); m_off = int'(HADDR[4:2]); m_wr = HWRITE; m_size = HSIZE[1:0];
            end else m_ph = 0;
        end
    end

    task automatic wait_acc();
        logic r;
        int n;
        n = 0;
        do begin
            @(negedge HCLK); r = HREADY; @(posedge HCLK); n++;
        end while (!r && n < 40);
        n_chk++;
        if (!r) begin
            n_err++;
            $display("FAIL accept: HREADY low for %0d cycles, required high within 40", n);
        end
        #1;
    endtask

    task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                        input logic wr, input logic [2:0] sz, input logic [31:0] wd);
        HSElx = sel; HTRANS = tr; HADDR = addr; HWRITE = wr; HSIZE = sz;
        wait_acc();
        HWDATA = wd;
    endtask

    task automatic idle();
        xfer(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
    endtask

    task automatic snap();
        s_bwe = n_bwe; s_str = n_str; s_stall = n_stall; s_err1 = n_err1;
        s_err2 = n_err2; s_rc = n_rc; s_poly = n_poly;
    endtask

    task automatic settle();
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        // POL write to channel 1
        snap();
        xfer(1, HTRANS_NONSEQ, 32'h34, 1, HSIZE_WORD, 32'h04C1_1DB7);
        idle(); settle();
        chk("poly_pulse_count", n_poly - s_poly, 1);
        chk("poly_ch_sel", poly_chsel, 2'b10);
        chk("poly_hreadyout", poly_rdy, 1);
        chk("poly_hresp", poly_resp, 0);
        // DR write held off by buffer_full for three cycles
        snap();
        xfer(1, HTRANS_NONSEQ, 32'h00, 1, HSIZE_WORD, 32'h0000_0011);
        buffer_full[0] = 1'b1;
        fork
            idle();
            begin repeat (3) @(posedge HCLK); #1 buffer_full[0] = 1'b0; end
        join
        settle();
        chk("full_stall_cycles", n_stall - s_stall, 3);
        chk("full_write_pulses", n_bwe - s_bwe, 1);
        // unmapped offset 6
        snap();
        xfer(1, HTRANS_NONSEQ, 32'h18, 0, HSIZE_WORD, 32'h0);
        idle(); settle();
        chk("off6_err1", n_err1 - s_err1, 1);
        chk("off6_err2", n_err2 - s_err2, 1);
        chk("off6_strobes", n_str - s_str, 0);
        // read_wait never drops: timeout after WM stalls
        snap();
        read_wait[0] = 1'b1;
        xfer(1, HTRANS_NONSEQ, 32'h00, 0, HSIZE_WORD, 32'h0);
        idle();
        read_wait[0] = 1'b0;
        settle();
        chk("tmo_stall_cycles", n_stall - s_stall, WM);
        chk("tmo_err1", n_err1 - s_err1, 1);
        chk("tmo_err2", n_err2 - s_err2, 1);
        chk("tmo_strobes", n_str - s_str, 0);
        // four-beat DR burst
        snap();
        b = wq.size();
        xfer(1, HTRANS_NONSEQ, 32'h00, 1, HSIZE_WORD, 32'hA000_0001);
        xfer(1, HTRANS_SEQ, 32'h00, 1, HSIZE_WORD, 32'hA000_0002);
        xfer(1, HTRANS_SEQ, 32'h00, 1, HSIZE_WORD, 32'hA000_0003);
        xfer(1, HTRANS_SEQ, 32'h00, 1, HSIZE_WORD, 32'hA000_0004);
        idle(); settle();
        chk("burst_pulses", n_bwe - s_bwe, 4);
        chk("burst_stalls", n_stall - s_stall, 0);
        chk("burst_run", max_run, 4);
        for (int i = 0; i < 4; i++)
            chk("burst_data", (wq.size() > b + i) ? wq[b + i] : 32'hX, 32'hA000_0001 + i);
        // CR write then read back
        snap();
        xfer(1, HTRANS_NONSEQ, 32'h08, 1, HSIZE_WORD, 32'h0000_00F9);
        xfer(1, HTRANS_NONSEQ, 32'h08, 0, HSIZE_WORD, 32'h0);
        idle(); settle();
        chk("cr_reset_chain", n_rc - s_rc, 1);
        chk("cr_poly_size", crc_poly_size[1:0], 2'd3);
        chk("cr_rev_in", rev_in_type[1:0], 2'd3);
        chk("cr_rev_out", rev_out_type[0], 1'b1);
        chk("cr_readback", rd_last, 32'h0000_00F8);
        // register reads and assorted rejected or ignored transfers
        xfer(1, HTRANS_NONSEQ, 32'h20, 0, HSIZE_WORD, 32'h0);
        idle(); settle();
        chk("dr1_read", rd_last, 32'hC1C1_5A5A);
        snap();
        xfer(1, HTRANS_NONSEQ, 32'h04, 0, HSIZE_WORD, 32'h0);
        xfer(1, HTRANS_NONSEQ, 32'h30, 0, HSIZE_WORD, 32'h0);
        xfer(1, HTRANS_NONSEQ, 32'h34, 0, HSIZE_WORD, 32'h0);
        xfer(1, HTRANS_NONSEQ, 32'h28, 1, 3'b000, 32'h0000_00FF);
        xfer(1, HTRANS_NONSEQ, 32'h40, 1, HSIZE_WORD, 32'h1);
        xfer(1, HTRANS_BUSY, 32'h00, 1, HSIZE_WORD, 32'h2);
        xfer(0, HTRANS_NONSEQ, 32'h00, 1, HSIZE_WORD, 32'h3);
        xfer(1, HTRANS_NONSEQ, 32'h20, 1, 3'b001, 32'h4);
        idle(); settle();
        chk("misc_err1", n_err1 - s_err1, 2);
        chk("misc_strobes", n_str - s_str, 1);
        chk("misc_write_pulses", n_bwe - s_bwe, 1);
        chk("misc_cr1_untouched", rev_out_type[1], 1'b0);
        // reset in the middle of a stalled write
        snap();
        buffer_full[1] = 1'b1;
        xfer(1, HTRANS_NONSEQ, 32'h20, 1, HSIZE_WORD, 32'hDEAD_BEEF);
        HSElx = 1'b0; HTRANS = HTRANS_IDLE;
        @(posedge HCLK); #1 HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0; buffer_full[1] = 1'b0;
        settle();
        chk("rst_abort_writes", n_bwe - s_bwe, 0);
        chk("rst_abort_errors", n_err1 - s_err1 + n_err2 - s_err2, 0);
        chk("rst_cr_cleared", crc_poly_size[1:0], 2'd0);
        snap();
        xfer(1, HTRANS_NONSEQ, 32'h14, 1, HSIZE_WORD, 32'h1EDC_6F41);
        idle(); settle();
        chk("post_rst_poly", n_poly - s_poly, 1);
        chk("post_rst_ch_sel", poly_chsel, 2'b01);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
